cpu_run_checker: RTL
====================

// Module: cpu_run_checker
// PURPOSE
//  Synthesizable self-check block for CPU_SingleCycle programs. Watches PC and Overflow while the
//  program runs, stops at a halt PC, then scans an array in data memory through a debug read port
//  and checks its ordering. Reports pass/fail, an error bitmask, cycle count and first bad index.
//  Replaces hand-edited halt-PC and sortedness checks with one parametrised block usable on board.
// PARAMETERS
//  HALT_PC      104     byte PC at which the run is considered finished
//  ARR_BASE     512     byte address of element 0 (word aligned)
//  ARR_LEN      12      number of 32-bit elements to check (0..1024)
//  ORDER        0       0 strict ascending, 1 strict descending, 2 non-decreasing, 3 non-increasing
//  SIGNED_CMP   1       1 signed 32-bit compare, 0 unsigned
//  EXPECT_OVF   1       1: Overflow must be high in the cycle PC==HALT_PC
//  TIMEOUT      100000  max run cycles before PC reaches HALT_PC (>=1)
// PORTS
//  clk         in   1   system clock, all state on rising edge
//  rst         in   1   asynchronous, active-low reset
//  pc          in   32  CPU program counter
//  overflow    in   1   CPU ALU overflow flag
//  dm_rdata    in   32  debug read data, combinational from dm_addr
//  dm_addr     out  32  debug read byte address
//  dm_re       out  1   debug read enable; top muxes DM address to dm_addr when high
//  cpu_hold    out  1   high in SCAN/DONE; CPU top must stop PC update
//  done        out  1   check complete (sticky until reset)
//  pass        out  1   valid when done: err_code==0
//  err_code    out  4   [0] unexpected overflow, [1] missing expected overflow, [2] timeout, [3] order
//  fail_index  out  10  index i of first element with bad order vs i-1; 0 if none
//  cycle_count out  32  run cycles from first RUN cycle to halt (saturating)
// BEHAVIOUR
//  Reset (rst=0, async): state RUN; all outputs 0; dm_addr=0; internal index and prev-word cleared.
//  RUN: each rising edge cycle_count+=1 (saturate at 2^32-1).
//   - pc==HALT_PC: if EXPECT_OVF && !overflow set err[1]; if !EXPECT_OVF && overflow set err[0];
//     go SCAN with i=0. Overflow in the halt cycle with EXPECT_OVF=1 is NOT unexpected.
//   - else overflow==1: set err[0], go DONE (no scan).
//   - else cycle_count reaches TIMEOUT: set err[2], go DONE. Halt in same cycle as timeout: halt wins.
//  SCAN: cpu_hold=1, dm_re=1, dm_addr=ARR_BASE+4*i (32-bit wrap). One element per cycle:
//   - i==0: latch dm_rdata into prev.
//   - i>0: compare prev vs dm_rdata per ORDER/SIGNED_CMP; on first violation set err[3] and
//     fail_index=i (later violations ignored); prev<=dm_rdata.
//   - after i==ARR_LEN-1 go DONE; scan takes exactly ARR_LEN cycles. ARR_LEN 0 or 1: no compares;
//     ARR_LEN 0 goes DONE the cycle after halt with dm_re never asserted.
//   - equal neighbours violate ORDER 0/1, accepted by ORDER 2/3.
//  DONE: done=1, pass=(err_code==0), cpu_hold=1, dm_re=0; all outputs frozen until reset.
//  done/pass/err_code/fail_index are registered; done rises one cycle after the final SCAN cycle.
//  err bits are sticky; err[1] and err[3] may both be set. pc/overflow ignored outside RUN.
//  Reset mid-SCAN or in DONE: immediate return to RUN state with all results cleared.
// TESTING
//  1 Bubble-sort program, 12 words ascending after run, overflow only at PC 104 -> done, pass=1,
//    err_code=0, cycle_count equals run length, dm_addr swept 512..556.
//  2 Same, word at 528 forced to 5 (< 0 at 524? use 0,22,5) -> err_code=4'b1000, fail_index=4.
//  3 Overflow pulsed at PC 40 -> err_code=4'b0001, done next cycle, dm_re never high, no scan.
//  4 PC stuck at 24, TIMEOUT=50 -> err_code=4'b0100 after 50 cycles, cycle_count=50.
//  5 EXPECT_OVF=1, overflow low at halt, array sorted -> err_code=4'b0010, scan completes, pass=0.
//  6 ORDER=2 with duplicates {1,1,2}, SIGNED_CMP=0 with 0xFFFFFFFF last -> pass=1; rst=0 mid-scan
//    -> all outputs 0 asynchronously, rerun completes normally.

Source files
------------

// File: rtl/cpu_run_checker.sv
// Run/scan self-check for a single-cycle CPU: watches PC and overflow until the halt PC,
// then sweeps an array in data memory through a debug port and checks its ordering.
module cpu_run_checker #(
    parameter logic [31:0] HALT_PC    = 32'd104,
    parameter logic [31:0] ARR_BASE   = 32'd512,
    parameter int unsigned ARR_LEN    = 12,
    parameter int unsigned ORDER      = 0,
    parameter bit          SIGNED_CMP = 1'b1,
    parameter bit          EXPECT_OVF = 1'b1,
    parameter logic [31:0] TIMEOUT    = 32'd100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        overflow,
    input  logic [31:0] dm_rdata,
    output logic [31:0] dm_addr,
    output logic        dm_re,
    output logic        cpu_hold,
    output logic        done,
    output logic        pass,
    output logic [3:0]  err_code,
    output logic [9:0]  fail_index,
    output logic [31:0] cycle_count
);

    typedef enum logic [1:0] {S_RUN, S_SCAN, S_DONE} state_t;

    localparam logic [9:0] LAST_IDX = (ARR_LEN == 0) ? 10'd0 : 10'(ARR_LEN - 1);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  err_q, err_d;
    logic [9:0]  fidx_q, fidx_d;
    logic [9:0]  idx_q, idx_d;
    logic [31:0] prev_q, prev_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;

    // Both compare modes share one 33-bit signed comparison; only the extension differs.
    function automatic logic order_bad(input logic [31:0] prev, input logic [31:0] cur);
        logic signed [32:0] p;
        logic signed [32:0] c;
        p = SIGNED_CMP ? {prev[31], prev} : {1'b0, prev};
        c = SIGNED_CMP ? {cur[31], cur} : {1'b0, cur};
        if (ORDER == 0)      return !(p < c);
        else if (ORDER == 1) return !(p > c);
        else if (ORDER == 2) return p > c;
        else                 return p < c;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fidx_d  = fidx_q;
        idx_d   = idx_q;
        prev_d  = prev_q;
        done_d  = done_q;
        case (state_q)
            S_RUN: begin
                cnt_d = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
                if (pc == HALT_PC) begin
                    if (EXPECT_OVF && !overflow) err_d[1] = 1'b1;
                    if (!EXPECT_OVF && overflow) err_d[0] = 1'b1;
                    idx_d = 10'd0;
                    if (ARR_LEN == 0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_SCAN;
                    end
                end else if (overflow) begin
                    err_d[0] = 1'b1;
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                end else if (cnt_d >= TIMEOUT) begin
                    err_d[2] = 1'b1;
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                end
            end
            S_SCAN: begin
                // Element 0 only primes prev; only the first violation is recorded.
                if (idx_q != 10'd0 && order_bad(prev_q, dm_rdata) && !err_q[3]) begin
                    err_d[3] = 1'b1;
                    fidx_d   = idx_q;
                end
                prev_d = dm_rdata;
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 10'd1;
                end
            end
            default: ;
        endcase
        pass_d = done_d && (err_d == 4'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RUN;
            cnt_q   <= 32'd0;
            err_q   <= 4'd0;
            fidx_q  <= 10'd0;
            idx_q   <= 10'd0;
            prev_q  <= 32'd0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fidx_q  <= fidx_d;
            idx_q   <= idx_d;
            prev_q  <= prev_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign dm_re       = (state_q == S_SCAN);
    assign dm_addr     = dm_re ? (ARR_BASE + {20'd0, idx_q, 2'b00}) : 32'd0;
    assign cpu_hold    = (state_q != S_RUN);
    assign done        = done_q;
    assign pass        = pass_q;
    assign err_code    = err_q;
    assign fail_index  = fidx_q;
    assign cycle_count = cnt_q;

endmodule
